debug_display: RTL and testbench

DEBUG_DISPLAY -- requirements
Module: debug_display

---
 rtl/debug_display_pkg.sv | 28 ++
 rtl/debug_display_if.sv | 32 +++
 rtl/debug_display_decoder7.sv | 32 +++
 rtl/debug_display.sv | 124 ++++++++++++
 tb/tb_debug_display.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/debug_display_pkg.sv
// debug_display_pkg: mode encodings, segment constants, width helpers.
// Shared by the interface, the top and the segment decoder.
package debug_display_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE   = 2'b00,
    MODE_HOLD   = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_SCROLL = 2'b11
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Width of a field that must index v items, never zero.
  function automatic int bits_for(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/debug_display_if.sv
// debug_display_if: probe/control inputs and display outputs.
// master drives iProbe/iSel/iMode/iCapture/iStep; slave drives oHex/oChannel/oWindow/oFrozen.
interface debug_display_if
  import debug_display_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32
);
  localparam int CH_W  = bits_for(NUM_CH);
  localparam int WIN_W = bits_for((DATA_W + 31) / 32);

  logic [NUM_CH*DATA_W-1:0] iProbe;
  logic [CH_W-1:0]          iSel;
  logic [1:0]               iMode;
  logic                     iCapture;
  logic                     iStep;
  logic [55:0]              oHex;
  logic [CH_W-1:0]          oChannel;
  logic [WIN_W-1:0]         oWindow;
  logic                     oFrozen;

  modport master (
    output iProbe, iSel, iMode, iCapture, iStep,
    input  oHex, oChannel, oWindow, oFrozen
  );

  modport slave (
    input  iProbe, iSel, iMode, iCapture, iStep,
    output oHex, oChannel, oWindow, oFrozen
  );

endinterface

// File: rtl/debug_display_decoder7.sv
// decoder7: combinational nibble to active-low 7-segment glyph.
// Ports: nibble (4b in), seg (7b out, bit order gfedcba).
module decoder7
  import debug_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/debug_display.sv
// debug_display: multi-channel probe viewer on eight 7-segment digits.
// Ports: iClock, iReset (sync, active-high), bus (debug_display_if.slave).
module debug_display
  import debug_display_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 32,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic           iClock,
  input  logic           iReset,
  debug_display_if.slave bus
);

  localparam int CH_W    = bits_for(NUM_CH);
  localparam int NUM_WIN = (DATA_W + 31) / 32;
  localparam int WIN_W   = bits_for(NUM_WIN);
  localparam int PRE_W   = bits_for(SCAN_DIV);
  localparam int PAD_W   = NUM_WIN * 32;
  localparam int ALL_W   = NUM_CH * DATA_W;

  mode_e              mode;
  mode_e              prev_mode;
  logic [ALL_W-1:0]   snap;
  logic [ALL_W-1:0]   src;
  logic               load;
  logic               scan_entry;
  logic               scan_adv;
  logic               scan_last;
  logic               win_last;
  logic               bad_ch;
  logic [CH_W-1:0]    scan_ch;
  logic [CH_W-1:0]    cur_ch;
  logic [WIN_W-1:0]   win;
  logic [WIN_W-1:0]   cur_win;
  logic [PRE_W-1:0]   presc;
  logic [DATA_W-1:0]  ch_data;
  logic [PAD_W-1:0]   padded;
  logic [31:0]        word;
  logic [6:0]         seg [8];
  logic [55:0]        hex_d;

  assign mode = mode_e'(bus.iMode);

  always_comb begin
    load = bus.iCapture ||
           (mode == MODE_HOLD &&
            prev_mode != MODE_HOLD);
    // A snapshot loaded this cycle is shown
    // straight away, keeping one-cycle latency.
    src = (mode == MODE_HOLD && !load) ?
          snap : bus.iProbe;
    scan_entry = mode == MODE_SCAN &&
                 prev_mode != MODE_SCAN;
    scan_adv = presc == PRE_W'(SCAN_DIV - 1) ||
               bus.iStep;
    scan_last = 32'(scan_ch) == NUM_CH - 1;
    win_last  = 32'(win) == NUM_WIN - 1;
    cur_ch = (mode == MODE_SCAN && !scan_entry) ?
             scan_ch : bus.iSel;
    cur_win = (mode == MODE_SCROLL) ? win : '0;
    bad_ch = 32'(cur_ch) >= NUM_CH;
    ch_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (cur_ch == CH_W'(k))
        ch_data = src[k*DATA_W +: DATA_W];
    padded = PAD_W'(ch_data);
    word = '0;
    for (int w = 0; w < NUM_WIN; w++)
      if (cur_win == WIN_W'(w))
        word = padded[w*32 +: 32];
  end

  for (genvar d = 0; d < 8; d++) begin : g_dec
    decoder7 u_dec (
      .nibble (word[4*d +: 4]),
      .seg    (seg[d])
    );
  end

  always_comb begin
    hex_d = '0;
    for (int d = 0; d < 8; d++)
      hex_d[7*d +: 7] = bad_ch ? SEG_DASH : seg[d];
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      prev_mode    <= MODE_LIVE;
      snap         <= '0;
      scan_ch      <= '0;
      presc        <= '0;
      win          <= '0;
      bus.oHex     <= {8{SEG_BLANK}};
      bus.oChannel <= '0;
      bus.oWindow  <= '0;
      bus.oFrozen  <= 1'b0;
    end else begin
      prev_mode <= mode;
      if (load) snap <= bus.iProbe;
      if (scan_entry) begin
        scan_ch <= bus.iSel;
        presc   <= '0;
      end else if (mode == MODE_SCAN) begin
        if (scan_adv) begin
          scan_ch <= scan_last ?
                     '0 : scan_ch + CH_W'(1);
          presc   <= '0;
        end else begin
          presc <= presc + PRE_W'(1);
        end
      end
      if (mode != MODE_SCROLL)
        win <= '0;
      else if (bus.iStep)
        win <= win_last ? '0 : win + WIN_W'(1);
      bus.oHex     <= hex_d;
      bus.oChannel <= cur_ch;
      bus.oWindow  <= cur_win;
      bus.oFrozen  <= mode == MODE_HOLD;
    end
  end

endmodule

// File: tb/tb_debug_display.sv
// tb_debug_display: random + directed stimulus vs reference model.
// Expected outputs are queued per cycle and checked by a monitor.
module tb_debug_display;
  import debug_display_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 48;
  localparam int SCAN_DIV = 4;
  localparam int NUM_WIN  = 2;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [55:0] hex;
    int          ch;
    int          win;
    bit          frozen;
  } exp_t;

  logic iClock = 1'b0;
  logic iReset = 1'b1;
  always #5 iClock = ~iClock;

  debug_display_if #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) bus ();

  debug_display #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t mon_e;

  logic [DATA_W-1:0] ch     [NUM_CH];
  logic [DATA_W-1:0] m_snap [NUM_CH];
  int m_prev, m_scan, m_presc, m_win;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [55:0] exp_hex(
    input logic [31:0] w);
    logic [55:0] r;
    for (int d = 0; d < 8; d++)
      r[7*d +: 7] = GLYPH[w[4*d +: 4]];
    return r;
  endfunction

  // One clock of stimulus plus the model's expected response.
  task automatic cycle(input bit rst,
                       input int mode,
                       input int sel,
                       input bit cap,
                       input bit step);
    exp_t e;
    int chn, w;
    logic [95:0] wide;
    logic [DATA_W-1:0] val;
    @(negedge iClock);
    iReset       = rst;
    bus.iMode    = 2'(mode);
    bus.iSel     = 2'(sel);
    bus.iCapture = cap;
    bus.iStep    = step;
    for (int k = 0; k < NUM_CH; k++)
      bus.iProbe[k*DATA_W +: DATA_W] = ch[k];
    if (rst) begin
      e.hex = {8{7'h7F}};
      e.ch = 0; e.win = 0; e.frozen = 0;
      m_prev = 0; m_scan = 0;
      m_presc = 0; m_win = 0;
      for (int k = 0; k < NUM_CH; k++)
        m_snap[k] = '0;
    end else begin
      if (cap || (mode == 1 && m_prev != 1))
        m_snap = ch;
      if (mode == 2 && m_prev != 2) chn = sel;
      else if (mode == 2) chn = m_scan;
      else chn = sel;
      w = (mode == 3) ? m_win : 0;
      val = (mode == 1) ? m_snap[chn] : ch[chn];
      wide = {48'h0, val};
      e.hex = exp_hex(wide[32*w +: 32]);
      e.ch = chn;
      e.win = w;
      e.frozen = (mode == 1);
      if (mode == 2 && m_prev != 2) begin
        m_scan = sel;
        m_presc = 0;
      end else if (mode == 2) begin
        if (m_presc == SCAN_DIV - 1 || step) begin
          m_scan = (m_scan + 1) % NUM_CH;
          m_presc = 0;
        end else begin
          m_presc++;
        end
      end
      if (mode != 3) m_win = 0;
      else if (step) m_win = (m_win + 1) % NUM_WIN;
      m_prev = mode;
    end
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge iClock);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("oHex", 64'(bus.oHex), 64'(mon_e.hex));
        chk("oChannel", 64'(bus.oChannel),
            64'(mon_e.ch));
        chk("oWindow", 64'(bus.oWindow),
            64'(mon_e.win));
        chk("oFrozen", 64'(bus.oFrozen),
            64'(mon_e.frozen));
      end
    end
  end

  initial begin
    bit done;
    int mode;
    for (int k = 0; k < NUM_CH; k++) ch[k] = '0;
    bus.iProbe = '0; bus.iSel = '0;
    bus.iMode = '0; bus.iCapture = 0;
    bus.iStep = 0;

    // reset beats capture/step
    cycle(1, 0, 0, 1, 1);
    cycle(1, 2, 1, 1, 1);
    cycle(1, 0, 0, 0, 0);

    // live view of channel 2
    ch[2] = 48'h0000_1234_ABCD;
    ch[0] = 48'hFFFF_5555_AAAA;
    for (int i = 0; i < 3; i++) cycle(0, 0, 2, 0, 0);
    @(posedge iClock); #1;
    chk("live_1234ABCD", 64'(bus.oHex),
        64'({7'h79, 7'h24, 7'h30, 7'h19,
             7'h08, 7'h03, 7'h46, 7'h21}));

    // scroll windows with wrap
    ch[2] = 48'hBEEF_0000_0001;
    for (int i = 0; i < 12; i++)
      cycle(0, 3, 2, 0, (i % 3) == 2);
    for (int i = 0; i < 2; i++) cycle(0, 0, 2, 0, 0);

    // hold then manual capture
    ch[1] = 48'd5;
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 1);
    ch[1] = 48'd9;
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 0);
    for (int i = 0; i < 2; i++) cycle(0, 1, 1, 0, 0);

    // auto-scan from 3, step on terminal count
    for (int k = 0; k < NUM_CH; k++)
      ch[k] = 48'(k * 48'h1111_1111 + 7);
    cycle(0, 0, 3, 0, 0);
    done = 0;
    for (int i = 0; i < 24; i++) begin
      if (!done && i > 8 &&
          m_presc == SCAN_DIV - 1) begin
        done = 1;
        cycle(0, 2, 3, 0, 1);
      end else begin
        cycle(0, 2, 3, 0, 0);
      end
    end

    // reset mid-scan with capture pending
    cycle(1, 2, 0, 1, 0);
    @(posedge iClock); #1;
    checks++;
    if (dut.snap !== '0) begin
      errors++;
      $display("FAIL snap_reset: got %0h expected 0",
               dut.snap);
    end
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);

    // randomized traffic
    mode = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 15)
        mode = $urandom_range(3);
      for (int k = 0; k < NUM_CH; k++)
        if ($urandom_range(99) < 30)
          ch[k] = {$urandom, $urandom};
      cycle($urandom_range(99) < 2, mode,
            $urandom_range(NUM_CH - 1),
            $urandom_range(99) < 8,
            $urandom_range(99) < 25);
    end

    @(posedge iClock);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d expected 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
